lcd_bus_writer: RTL and testbench

LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

---
 rtl/lcd_bus_writer.sv | 172 +++++++++++++++++
 tb/tb_lcd_bus_writer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_writer.sv
// HD44780 write-only bus writer: paces each byte through setup, E strobe, hold and execution delay.
// Define LCD_INIT_SEQ_EN to issue the 8-bit power-on command sequence before accepting requests.
module lcd_bus_writer #(
  parameter bit SIM_SPEEDUP = 1'b0
) (
  input  logic       clk_40MHz,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_D
);

  typedef enum logic [2:0] {
    POWER_WAIT,
    INIT_ISSUE,
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    EXEC_WAIT
  } state_t;

  // Counter loads are duration-1: the state is left on the cycle the count reads zero.
  localparam logic [19:0] PW_LOAD    = SIM_SPEEDUP ? 20'd63 : 20'd599999;
  localparam logic [19:0] SHORT_LOAD = SIM_SPEEDUP ? 20'd7  : 20'd1599;
  localparam logic [19:0] LONG_LOAD  = SIM_SPEEDUP ? 20'd31 : 20'd65599;
  localparam logic [19:0] SETUP_LOAD = 20'd1;
  localparam logic [19:0] E_LOAD     = 20'd9;
  localparam logic [19:0] HOLD_LOAD  = 20'd1;

  state_t      state_q;
  logic [19:0] cnt_q;
  logic [19:0] exec_load_d;
  logic        ready_q;
  logic        done_q;
  logic        rs_q;
  logic        e_q;
  logic [7:0]  d_q;

  // Clear display and return home need the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d >= 8'h01) && (d <= 8'h03);
  endfunction

`ifdef LCD_INIT_SEQ_EN
  logic [2:0] idx_q;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction
`endif

  assign exec_load_d = is_long_cmd(rs_q, d_q) ? LONG_LOAD : SHORT_LOAD;

  always_ff @(posedge clk_40MHz) begin
    if (reset) begin
      state_q <= POWER_WAIT;
      cnt_q   <= PW_LOAD;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      d_q     <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
      idx_q   <= 3'd0;
`endif
    end else begin
      case (state_q)
        POWER_WAIT: begin
          if (cnt_q == 20'd0) begin
`ifdef LCD_INIT_SEQ_EN
            state_q <= INIT_ISSUE;
`else
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
`ifdef LCD_INIT_SEQ_EN
        INIT_ISSUE: begin
          rs_q    <= 1'b0;
          d_q     <= init_cmd(idx_q);
          idx_q   <= idx_q + 3'd1;
          state_q <= SETUP;
          cnt_q   <= SETUP_LOAD;
        end
`endif
        IDLE: begin
          if (wr_valid) begin
            ready_q <= 1'b0;
            rs_q    <= wr_rs;
            d_q     <= wr_data;
            state_q <= SETUP;
            cnt_q   <= SETUP_LOAD;
          end
        end
        SETUP: begin
          if (cnt_q == 20'd0) begin
            state_q <= E_HIGH;
            e_q     <= 1'b1;
            cnt_q   <= E_LOAD;
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        E_HIGH: begin
          if (cnt_q == 20'd0) begin
            state_q <= HOLD;
            e_q     <= 1'b0;
            cnt_q   <= HOLD_LOAD;
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 20'd0) begin
            state_q <= EXEC_WAIT;
            cnt_q   <= exec_load_d;
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        EXEC_WAIT: begin
          if (cnt_q == 20'd0) begin
            cnt_q <= 20'd0;
`ifdef LCD_INIT_SEQ_EN
            if (idx_q == 3'd6) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= INIT_ISSUE;
            end
`else
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        default: begin
          state_q <= POWER_WAIT;
          cnt_q   <= PW_LOAD;
        end
      endcase
    end
  end

  assign wr_ready  = ready_q;
  assign init_done = done_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_E     = e_q;
  assign LCD_D     = d_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Randomised and directed bench for lcd_bus_writer against a cycle-timeline model of the bus protocol.
module tb_lcd_bus_writer;

  logic       clk = 1'b0;
  logic       reset, wr_valid, wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready, init_done, LCD_RS, LCD_RW, LCD_E;
  logic [7:0] LCD_D;

  always #12 clk = ~clk;

  lcd_bus_writer #(.SIM_SPEEDUP(1'b1)) dut (
    .clk_40MHz(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rs(wr_rs), .wr_data(wr_data), .init_done(init_done),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_D(LCD_D)
  );

`ifdef LCD_INIT_SEQ_EN
  localparam int INIT_N   = 6;
  localparam int EXP_WAIT = 226;  // 64 power-on + 5*(15+8) + (15+32)
`else
  localparam int INIT_N   = 0;
  localparam int EXP_WAIT = 64;
`endif
  localparam int PW = 64;

  int total = 0;
  int bad   = 0;

  logic [7:0] init_tab [6];
  initial init_tab = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Model: cycles since reset, cycles since the current byte was accepted, and what the bus holds.
  bit         mvalid = 1'b0;
  int         since_rst = 0;
  int         k = -1;
  int         n = 8;
  int         idx = 6;
  bit         done = 1'b0;
  logic       mrs = 1'b0;
  logic [7:0] md = 8'h00;

  function automatic int delay_of(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? 32 : 8;
  endfunction

  function automatic bit m_pw();
    return since_rst < PW;
  endfunction

  function automatic bit m_ready();
    return !m_pw() && k < 0 && idx == 6;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mvalid = 1'b1; since_rst = 0; k = -1; idx = 6 - INIT_N;
      done = 1'b0; mrs = 1'b0; md = 8'h00;
    end else if (mvalid) begin
      if (m_pw()) begin
        since_rst++;
      end else if (k >= 0) begin
        k++;
        if (k == 15 + n) k = -1;
      end else if (idx < 6) begin
        mrs = 1'b0; md = init_tab[idx]; n = delay_of(mrs, md); idx++; k = 1;
      end else begin
        done = 1'b1;
        if (wr_valid) begin
          mrs = wr_rs; md = wr_data; n = delay_of(mrs, md); k = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      logic ex_ready, ex_done, ex_e;
      ex_ready = m_ready();
      ex_done  = done || ex_ready;
      ex_e     = (k >= 3 && k <= 12);
      total++;
      if (wr_ready !== ex_ready || init_done !== ex_done || LCD_E !== ex_e ||
          LCD_RS !== mrs || LCD_D !== md || LCD_RW !== 1'b0) begin
        bad++;
        $display("FAIL cycle t=%0t got rdy=%b done=%b E=%b RS=%b D=%h RW=%b want rdy=%b done=%b E=%b RS=%b D=%h RW=0",
                 $time, wr_ready, init_done, LCD_E, LCD_RS, LCD_D, LCD_RW,
                 ex_ready, ex_done, ex_e, mrs, md);
      end
    end
  end

  // Record every E rising edge with the byte it carried and the cycle it appeared.
  logic [8:0] pulse_q [$];
  int         ptime_q [$];
  int         ncyc = 0;
  logic       e_prev = 1'b0;
  always @(negedge clk) begin
    ncyc++;
    if (LCD_E === 1'b1 && e_prev !== 1'b1) begin
      pulse_q.push_back({LCD_RS, LCD_D});
      ptime_q.push_back(ncyc);
    end
    e_prev = LCD_E;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (wr_ready !== 1'b1 && cnt < 5000) begin
      step();
      cnt++;
    end
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, output int lat,
                          output int first_e, output int ecnt, output int dok, output int dend);
    int kk;
    wr_valid = 1'b1; wr_rs = rs; wr_data = d;
    step();
    dok = (LCD_D === d && LCD_RS === rs) ? 1 : 0;
    wr_valid = 1'b0;
    kk = 1; first_e = -1; ecnt = 0;
    while (wr_ready !== 1'b1 && kk < 200) begin
      if (LCD_E === 1'b1) begin
        if (first_e < 0) first_e = kk;
        ecnt++;
      end
      if (kk < 12) begin
        wr_valid = 1'($urandom_range(1, 0)); wr_data = 8'($urandom); wr_rs = 1'($urandom);
      end else begin
        wr_valid = 1'b0;
      end
      step();
      kk++;
    end
    lat = kk;
    dend = (LCD_D === d && LCD_RS === rs) ? 1 : 0;
  endtask

  typedef struct { logic rs; logic [7:0] d; int lat; } wr_t;
  wr_t wtab [7];
  initial wtab = '{'{1'b1, 8'h41, 23}, '{1'b0, 8'h01, 47}, '{1'b0, 8'h00, 23},
                   '{1'b0, 8'h03, 47}, '{1'b0, 8'h04, 23}, '{1'b1, 8'h02, 23},
                   '{1'b0, 8'h02, 47}};

  initial begin
    int cnt, lat, fe, ec, dok, dend, sz0, mode;
    reset = 1'b1; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
    repeat (3) step();
    chk("rst_ready", int'(wr_ready), 0);
    chk("rst_done", int'(init_done), 0);
    chk("rst_E", int'(LCD_E), 0);
    chk("rst_D", int'(LCD_D), 0);
    pulse_q.delete(); ptime_q.delete();
    reset = 1'b0;
    wait_ready(cnt);
    chk("power_on_wait", cnt, EXP_WAIT);
    chk("init_done_up", int'(init_done), 1);
    chk("init_pulses", pulse_q.size(), INIT_N);
    for (int i = 0; i < INIT_N && i < pulse_q.size(); i++)
      chk("init_byte", int'(pulse_q[i]), int'({1'b0, init_tab[i]}));

    foreach (wtab[i]) begin
      sz0 = pulse_q.size();
      do_write(wtab[i].rs, wtab[i].d, lat, fe, ec, dok, dend);
      chk("wr_latency", lat, wtab[i].lat);
      chk("e_first", fe, 3);
      chk("e_width", ec, 10);
      chk("bus_at_T1", dok, 1);
      chk("bus_held", dend, 1);
      chk("one_pulse", pulse_q.size() - sz0, 1);
    end

    // Back-to-back with wr_valid held high.
    sz0 = pulse_q.size();
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h48;
    step();
    wr_data = 8'h49;
    wait_ready(cnt);
    step();
    wr_valid = 1'b0;
    wait_ready(cnt);
    chk("b2b_pulses", pulse_q.size() - sz0, 2);
    if (pulse_q.size() - sz0 == 2) begin
      chk("b2b_byte0", int'(pulse_q[sz0]), 9'h148);
      chk("b2b_byte1", int'(pulse_q[sz0 + 1]), 9'h149);
      chk("b2b_gap", ptime_q[sz0 + 1] - ptime_q[sz0], 23);
    end

    // Reset landing while E is high.
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h55;
    step();
    wr_valid = 1'b0;
    repeat (4) step();
    chk("pre_rst_E", int'(LCD_E), 1);
    reset = 1'b1;
    step();
    chk("mid_rst_E", int'(LCD_E), 0);
    chk("mid_rst_ready", int'(wr_ready), 0);
    chk("mid_rst_done", int'(init_done), 0);
    chk("mid_rst_D", int'(LCD_D), 0);
    pulse_q.delete(); ptime_q.delete();
    reset = 1'b0;
    wait_ready(cnt);
    chk("restart_wait", cnt, EXP_WAIT);
    chk("restart_pulses", pulse_q.size(), INIT_N);

    // Random traffic, with occasional resets, checked cycle by cycle by the model.
    mode = 0;
    for (int c = 0; c < 6000; c++) begin
      if (c % 60 == 0) mode = int'($urandom_range(2, 0));
      reset = ($urandom_range(1999, 0) == 0);
      case (mode)
        0: wr_valid = 1'b1;
        1: wr_valid = ($urandom_range(3, 0) == 0);
        default: wr_valid = 1'($urandom);
      endcase
      wr_rs   = 1'($urandom);
      wr_data = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(4, 0)) : 8'($urandom);
      step();
    end
    reset = 1'b0; wr_valid = 1'b0;
    wait_ready(cnt);
    chk("final_ready", int'(wr_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
